// File: rtl/spsram_ctrl.sv
// Single-port SRAM controller: request/response front end driving a synchronous SRAM.
// Define SPSRAM_CTRL_BURST_EN to enable multi-beat reads via i_req_len; otherwise every read is one beat.
module spsram_ctrl #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 6,
  parameter int BW_LEN  = 2
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req_valid,
  output logic               o_req_ready,
  input  logic               i_req_wr,
  input  logic [BW_ADDR-1:0] i_req_addr,
  input  logic [BW_DATA-1:0] i_req_wdata,
`ifdef SPSRAM_CTRL_BURST_EN
  input  logic [BW_LEN-1:0]  i_req_len,
`endif
  output logic               o_rsp_valid,
  output logic [BW_DATA-1:0] o_rsp_rdata,
  output logic               o_rsp_last,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic [BW_DATA-1:0] o_mem_data,
  output logic               o_mem_wen,
  output logic               o_mem_cen,
  output logic               o_mem_oen,
  input  logic [BW_DATA-1:0] i_mem_data
);

  typedef enum logic [1:0] {IDLE, WR, RD, DRAIN} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BW_LEN-1:0] req_len;
  logic [BW_LEN-1:0] len_q;
  logic [BW_LEN-1:0] beat_cnt;
  logic              drain_cnt;
  logic              accept;
  logic              last_issue;
  logic              rd_pend;
  logic              rd_pend_last;

`ifdef SPSRAM_CTRL_BURST_EN
  assign req_len = i_req_len;
`else
  assign req_len = '0;
`endif

  assign o_req_ready = (state == IDLE) && !i_rst;
  assign accept      = i_req_valid && o_req_ready;
  assign last_issue  = (state == RD) && (beat_cnt == len_q);

  always_comb begin
    state_nxt = state;
    o_mem_cen = 1'b0;
    o_mem_wen = 1'b0;
    o_mem_oen = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = i_req_wr ? WR : RD;
      end
      WR: begin
        o_mem_cen = 1'b1;
        o_mem_wen = 1'b1;
        state_nxt = IDLE;
      end
      RD: begin
        o_mem_cen = 1'b1;
        o_mem_oen = 1'b1;
        if (beat_cnt == len_q) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Address/data are registered so they naturally hold in IDLE and DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_q      <= '0;
      beat_cnt   <= '0;
      drain_cnt  <= 1'b0;
      o_mem_addr <= '0;
      o_mem_data <= '0;
    end else begin
      if (accept) begin
        o_mem_addr <= i_req_addr;
        len_q      <= i_req_wr ? '0 : req_len;
        beat_cnt   <= '0;
        drain_cnt  <= 1'b0;
        if (i_req_wr) o_mem_data <= i_req_wdata;
      end else if ((state == RD) && !last_issue) begin
        beat_cnt   <= beat_cnt + 1'b1;
        o_mem_addr <= o_mem_addr + 1'b1;
      end
      if (state == DRAIN) drain_cnt <= ~drain_cnt;
    end
  end

  // Two-stage tag pipeline matches the SRAM read latency plus the rdata register.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rd_pend      <= 1'b0;
      rd_pend_last <= 1'b0;
      o_rsp_valid  <= 1'b0;
      o_rsp_last   <= 1'b0;
      o_rsp_rdata  <= '0;
    end else begin
      rd_pend      <= (state == RD);
      rd_pend_last <= last_issue;
      o_rsp_valid  <= rd_pend;
      o_rsp_last   <= rd_pend_last;
      if (rd_pend) o_rsp_rdata <= i_mem_data;
    end
  end

endmodule
